// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive framer and related Ethernet RX blocks.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_POLY_REF  = 32'hEDB88320;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 step: advances a reflected IEEE 802.3 CRC by one byte, LSB first.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;
  logic        fb;

  always_comb begin
    c  = crc_i;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data_i[i];
      c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY_REF : 32'h0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, streams the body without FCS through a
// 5-byte delay line, and reports CRC, length and PHY-error status per frame.
module gmii_rx_frame
  import eth_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] frame_len,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_phy,
  output logic [1:0]  dbg_state_o
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [10:0] FCS_L = 11'd5;

  rx_state_e       state_q;
  logic [10:0]     len_q;
  logic [10:0]     len_d;
  logic [31:0]     crc_q;
  logic [31:0]     crc_d;
  logic            phy_q;
  logic            phy_d;
  logic [4:0][7:0] dl_q;

  logic            out_valid_q, out_sof_q, out_eof_q, frame_done_q;
  logic            frame_ok_q, err_crc_q, err_len_q, err_phy_q;
  logic [7:0]      out_data_q;
  logic [10:0]     frame_len_q;

  logic            end_crc_bad;
  logic            end_len_bad;
  logic            has_beat;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (gmii_rxd),
    .crc_o  (crc_d)
  );

  assign len_d       = len_q + 11'd1;
  assign phy_d       = phy_q | gmii_rx_er;
  assign end_crc_bad = (crc_q != CRC_RESIDUE);
  assign end_len_bad = (len_q < MIN_L) || (len_q > MAX_L);
  // Once five bytes are buffered, the oldest is a body byte (never part of the FCS).
  assign has_beat    = (len_q >= FCS_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DROP;
      len_q        <= '0;
      crc_q        <= CRC_INIT;
      phy_q        <= 1'b0;
      dl_q         <= '0;
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_len_q  <= '0;
      err_crc_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_phy_q    <= 1'b0;
    end else begin
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_DROP: begin
          if (!gmii_rx_dv) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (gmii_rx_dv) state_q <= (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_q <= ST_IDLE;
          end else if (gmii_rxd == SFD_BYTE) begin
            state_q <= ST_DATA;
            len_q   <= '0;
            crc_q   <= CRC_INIT;
            phy_q   <= 1'b0;
          end else if (gmii_rxd != PREAMBLE_BYTE) begin
            state_q <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (gmii_rx_dv) begin
            len_q <= len_d;
            crc_q <= crc_d;
            phy_q <= phy_d;
            dl_q  <= {dl_q[3:0], gmii_rxd};
            if (has_beat) begin
              out_valid_q <= 1'b1;
              out_data_q  <= dl_q[4];
              out_sof_q   <= (len_q == FCS_L);
            end
            // Oversized frame: close it out on this byte and discard the remainder.
            if (len_q == MAX_L) begin
              out_eof_q    <= 1'b1;
              frame_done_q <= 1'b1;
              frame_len_q  <= len_d;
              err_crc_q    <= 1'b0;
              err_len_q    <= 1'b1;
              err_phy_q    <= phy_d;
              frame_ok_q   <= 1'b0;
              state_q      <= ST_DROP;
            end
          end else begin
            frame_done_q <= 1'b1;
            frame_len_q  <= len_q;
            err_crc_q    <= end_crc_bad;
            err_len_q    <= end_len_bad;
            err_phy_q    <= phy_q;
            frame_ok_q   <= !(end_crc_bad || end_len_bad || phy_q);
            state_q      <= ST_IDLE;
            if (has_beat) begin
              out_valid_q <= 1'b1;
              out_data_q  <= dl_q[4];
              out_eof_q   <= 1'b1;
              out_sof_q   <= (len_q == FCS_L);
            end
          end
        end
        default: state_q <= ST_DROP;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sof     = out_sof_q;
  assign out_eof     = out_eof_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign frame_len   = frame_len_q;
  assign err_crc     = err_crc_q;
  assign err_len     = err_len_q;
  assign err_phy     = err_phy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Bench for gmii_rx_frame: frame-level reference model, beat scoreboard, table and random frames.
module tb_gmii_rx_frame;
  import eth_rx_pkg::*;

  localparam int MIN = 64;
  localparam int MAX = 1518;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        out_valid, out_sof, out_eof, frame_done, frame_ok;
  logic [7:0]  out_data;
  logic [10:0] frame_len;
  logic        err_crc, err_len, err_phy;
  logic [1:0]  dbg_state;

  gmii_rx_frame #(.MIN_LEN(MIN), .MAX_LEN(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .frame_ok(frame_ok), .frame_len(frame_len),
    .err_crc(err_crc), .err_len(err_len), .err_phy(err_phy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #4 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int ok_cnt   = 0;
  logic [9:0] exp_q[$];            // {sof, eof, data}
  logic [7:0] body [0:2047];

  typedef struct {
    int n; bit pat; bit corrupt; int er_pos;
    bit ok; bit crc; bit len_e; bit phy; int flen; int beats; bit chk_crc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid) begin
        beat_cnt++;
        if (exp_q.size() == 0) check("unexpected_beat", {out_sof, out_eof, out_data}, 10'h3ff);
        else check("beat", {out_sof, out_eof, out_data}, exp_q.pop_front());
      end else if (out_sof || out_eof) begin
        check("sof_eof_without_valid", {out_sof, out_eof}, 2'b00);
      end
      if (frame_done) begin
        done_cnt++;
        if (frame_ok) ok_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic vec_t model(input int n, input bit corrupt, input int er_pos);
    vec_t v;
    v.n = n; v.pat = 0; v.corrupt = corrupt; v.er_pos = er_pos; v.chk_crc = 1;
    v.flen  = (n > MAX) ? MAX + 1 : n;
    v.len_e = (n < MIN) || (n > MAX);
    v.crc   = (n <= MAX) && corrupt;
    v.phy   = (er_pos != 0) && (er_pos <= v.flen);
    v.beats = (n > MAX) ? MAX - 4 : ((n >= 5) ? n - 4 : 0);
    v.ok    = !(v.len_e || v.crc || v.phy);
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input bit dv, input bit er, input logic [7:0] d);
    @(negedge clk);
    gmii_rx_dv = dv; gmii_rx_er = er; gmii_rxd = d;
  endtask

  task automatic send_frame(input int n, input bit pat, input bit corrupt, input int er_pos,
                            input int pre, input int ipg);
    logic [31:0] c;
    int nb, ci;
    if (n >= 5) begin
      c = 32'hFFFFFFFF;
      for (int i = 1; i <= n - 4; i++) begin
        body[i] = pat ? 8'(i - 1) : 8'($urandom);
        c = crc_byte(c, body[i]);
      end
      c = ~c;
      for (int j = 0; j < 4; j++) body[n - 3 + j] = c[8*j +: 8];
      if (corrupt) begin
        ci = pat ? 17 : int'($urandom_range(1, n - 4));
        body[ci] = ~body[ci];
      end
    end else begin
      for (int i = 1; i <= n; i++) body[i] = 8'($urandom);
    end
    nb = (n > MAX) ? MAX - 4 : ((n >= 5) ? n - 4 : 0);
    for (int k = 1; k <= nb; k++) exp_q.push_back({k == 1, k == nb, body[k]});
    repeat (pre) drive(1, 0, PREAMBLE_BYTE);
    drive(1, 0, SFD_BYTE);
    for (int k = 1; k <= n; k++) drive(1, k == er_pos, body[k]);
    repeat (ipg) drive(0, 0, 8'($urandom));
  endtask

  task automatic wait_done(input int target, input string tag);
    int t;
    t = 0;
    while (done_cnt < target && t < 60) begin
      @(posedge clk); #2; t++;
    end
    repeat (4) begin @(posedge clk); #2; end
    check({tag, " done_count"}, done_cnt, target);
  endtask

  task automatic check_status(input vec_t v, input string tag, input int beats_before);
    check({tag, " frame_ok"},  frame_ok,  v.ok);
    if (v.chk_crc) check({tag, " err_crc"}, err_crc, v.crc);
    check({tag, " err_len"},   err_len,   v.len_e);
    check({tag, " err_phy"},   err_phy,   v.phy);
    check({tag, " frame_len"}, frame_len, v.flen);
    check({tag, " beats"},     beat_cnt - beats_before, v.beats);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[15];

  initial begin
    vec_t v;
    int d0, b0, o0, n;

    tbl[0]  = '{64,   1, 0, 0,    1, 0, 0, 0, 64,   60,   1};
    tbl[1]  = '{64,   1, 1, 0,    0, 1, 0, 0, 64,   60,   1};
    tbl[2]  = '{64,   1, 0, 20,   0, 0, 0, 1, 64,   60,   1};
    tbl[3]  = '{1600, 1, 0, 0,    0, 0, 1, 0, 1519, 1514, 1};
    tbl[4]  = '{64,   1, 0, 0,    1, 0, 0, 0, 64,   60,   1};
    tbl[5]  = '{1518, 0, 0, 0,    1, 0, 0, 0, 1518, 1514, 1};
    tbl[6]  = '{1519, 0, 0, 0,    0, 0, 1, 0, 1519, 1514, 1};
    tbl[7]  = '{63,   0, 0, 0,    0, 0, 1, 0, 63,   59,   1};
    tbl[8]  = '{65,   0, 0, 0,    1, 0, 0, 0, 65,   61,   1};
    tbl[9]  = '{5,    0, 0, 0,    0, 0, 1, 0, 5,    1,    1};
    tbl[10] = '{4,    0, 0, 0,    0, 0, 1, 0, 4,    0,    0};
    tbl[11] = '{0,    0, 0, 0,    0, 0, 1, 0, 0,    0,    0};
    tbl[12] = '{64,   0, 1, 7,    0, 1, 0, 1, 64,   60,   1};
    tbl[13] = '{1600, 0, 0, 1560, 0, 0, 1, 0, 1519, 1514, 1};
    tbl[14] = '{1600, 0, 0, 1519, 0, 0, 1, 1, 1519, 1514, 1};

    rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {out_valid, out_sof, out_eof, frame_done, frame_ok,
                            err_crc, err_len, err_phy, frame_len, out_data}, 0);
    check("reset_state", dbg_state, ST_DROP);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 15; i++) begin
      d0 = done_cnt; b0 = beat_cnt;
      send_frame(tbl[i].n, tbl[i].pat, tbl[i].corrupt, tbl[i].er_pos, 7, 2);
      wait_done(d0 + 1, $sformatf("tbl%0d", i));
      check_status(tbl[i], $sformatf("tbl%0d", i), b0);
    end

    // Aborted preamble: no beats and no frame_done
    d0 = done_cnt; b0 = beat_cnt;
    drive(1, 0, 8'h55); drive(1, 0, 8'h55); drive(1, 0, 8'hA3);
    drive(1, 0, 8'hD5); drive(1, 0, 8'h12); drive(1, 0, 8'h34);
    repeat (3) drive(0, 0, 8'h00);
    repeat (4) begin @(posedge clk); #2; end
    check("abort_no_done", done_cnt, d0);
    check("abort_no_beats", beat_cnt, b0);

    // Two good frames with a single idle cycle between them
    d0 = done_cnt; o0 = ok_cnt;
    send_frame(64, 0, 0, 0, 7, 1);
    send_frame(70, 0, 0, 0, 7, 1);
    wait_done(d0 + 2, "b2b");
    check("b2b_ok_count", ok_cnt - o0, 2);

    // Asynchronous reset in the middle of a frame, released while dv is still high
    repeat (7) drive(1, 0, PREAMBLE_BYTE);
    drive(1, 0, SFD_BYTE);
    for (int k = 1; k <= 20; k++) begin
      body[k] = 8'($urandom);
      if (k <= 15) exp_q.push_back({k == 1, 1'b0, body[k]});
      drive(1, 0, body[k]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {out_valid, out_sof, out_eof, frame_done, frame_ok,
                               err_crc, err_len, err_phy, frame_len, out_data}, 0);
    d0 = done_cnt; b0 = beat_cnt;
    drive(1, 0, 8'h55); drive(1, 0, 8'h55);
    rst_n = 1'b1;
    drive(1, 0, 8'h55); drive(1, 0, 8'hD5);
    for (int k = 0; k < 12; k++) drive(1, 0, 8'($urandom));
    drive(0, 0, 8'h00);
    repeat (4) begin @(posedge clk); #2; end
    check("midreset_no_done", done_cnt, d0);
    check("midreset_no_beats", beat_cnt, b0);
    d0 = done_cnt; b0 = beat_cnt;
    send_frame(64, 1, 0, 0, 7, 2);
    wait_done(d0 + 1, "post_reset");
    check_status(tbl[0], "post_reset", b0);

    // Randomized frames against the reference model
    for (int i = 0; i < 25; i++) begin
      bit cor;
      int er;
      n   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1510, 1530)) : int'($urandom_range(5, 150));
      cor = ($urandom_range(0, 3) == 0);
      er  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n)) : 0;
      v   = model(n, cor, er);
      d0 = done_cnt; b0 = beat_cnt;
      send_frame(n, 0, cor, er, int'($urandom_range(1, 7)), int'($urandom_range(1, 3)));
      wait_done(d0 + 1, $sformatf("rnd%0d_n%0d", i, n));
      check_status(v, $sformatf("rnd%0d_n%0d", i, n), b0);
    end

    check("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
